// File: rtl/lfsr_test_sequencer.sv
// LFSR self-test sequencer: drives an LFSR generator/checker top through
// seed load, lock acquire, clean run, corruption and relock, then reports.
//
// Ports:
//   clk, i_rst (async, active-low)
//   i_start, i_seed, i_run_len, i_corrupt_len, i_timeout : test request
//   i_lock                                               : checker lock flag
//   o_soft_reset, o_valid, o_seed, o_corrupt             : to LFSR top
//   o_busy, o_done, o_pass, o_err                        : result to host
//   o_unlock_cnt (only with LFSR_SEQ_STATS_EN)           : lock-loss count
//
// Optional feature macro: LFSR_SEQ_STATS_EN
module lfsr_test_sequencer #(
    parameter int SEED_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [SEED_W-1:0] i_seed,
    input  logic [CNT_W-1:0]  i_run_len,
    input  logic [CNT_W-1:0]  i_corrupt_len,
    input  logic [CNT_W-1:0]  i_timeout,
    input  logic              i_lock,
    output logic              o_soft_reset,
    output logic              o_valid,
    output logic [SEED_W-1:0] o_seed,
    output logic              o_corrupt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
`ifdef LFSR_SEQ_STATS_EN
    output logic [1:0]        o_err,
    output logic [CNT_W-1:0]  o_unlock_cnt
`else
    output logic [1:0]        o_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACQ,
        S_RUN,
        S_CORR,
        S_RELOCK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   run_last_q, run_last_d;
    logic [CNT_W-1:0]   corr_last_q, corr_last_d;
    logic [CNT_W-1:0]   to_last_q, to_last_d;
    logic               flag_q, flag_d;
    logic [SEED_W-1:0]  seed_d;
    logic               pass_d;
    logic [1:0]         err_d;

    // Lengths are stored as their last counter value; a zero length is
    // treated as one cycle, so the counter never needs to wrap.
    function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_last_d  = run_last_q;
        corr_last_d = corr_last_q;
        to_last_d   = to_last_q;
        flag_d      = flag_q;
        seed_d      = o_seed;
        pass_d      = o_pass;
        err_d       = o_err;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    seed_d      = i_seed;
                    run_last_d  = last_of(i_run_len);
                    corr_last_d = last_of(i_corrupt_len);
                    to_last_d   = last_of(i_timeout);
                    pass_d      = 1'b0;
                    err_d       = 2'd0;
                    cnt_d       = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_ACQ;
            end
            S_ACQ: begin
                if (i_lock) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (cnt_q == to_last_q) begin
                    err_d   = 2'd1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!i_lock) begin
                    err_d   = 2'd1;
                    state_d = S_DONE;
                end else if (cnt_q == run_last_q) begin
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                    state_d = S_CORR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CORR: begin
                // Loss of lock in the final corruption cycle still counts.
                flag_d = flag_q | ~i_lock;
                if (cnt_q == corr_last_q) begin
                    cnt_d = '0;
                    if (flag_d) begin
                        state_d = S_RELOCK;
                    end else begin
                        err_d   = 2'd2;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELOCK: begin
                if (i_lock) begin
                    err_d   = 2'd0;
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == to_last_q) begin
                    err_d   = 2'd3;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            run_last_q   <= '0;
            corr_last_q  <= '0;
            to_last_q    <= '0;
            flag_q       <= 1'b0;
            o_soft_reset <= 1'b0;
            o_valid      <= 1'b0;
            o_seed       <= '0;
            o_corrupt    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_err        <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_last_q   <= run_last_d;
            corr_last_q  <= corr_last_d;
            to_last_q    <= to_last_d;
            flag_q       <= flag_d;
            o_soft_reset <= (state_d == S_LOAD);
            o_valid      <= (state_d == S_ACQ) || (state_d == S_RUN) ||
                            (state_d == S_CORR) || (state_d == S_RELOCK);
            o_seed       <= seed_d;
            o_corrupt    <= (state_d == S_CORR);
            o_busy       <= (state_d != S_IDLE);
            o_done       <= (state_d == S_DONE);
            o_pass       <= pass_d;
            o_err        <= err_d;
        end
    end

`ifdef LFSR_SEQ_STATS_EN
    logic lock_q;

    // Counts falling edges of i_lock seen while a test is in progress.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            lock_q       <= 1'b0;
            o_unlock_cnt <= '0;
        end else begin
            lock_q <= i_lock;
            if (state_q == S_IDLE && i_start) begin
                o_unlock_cnt <= '0;
            end else if (o_busy && lock_q && !i_lock &&
                         o_unlock_cnt != '1) begin
                o_unlock_cnt <= o_unlock_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
